// File: rtl/sat_pkg.sv
// Shared constants, result type and clamp-limit helpers for the
// saturating adder/accumulator datapath.
package sat_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Widest operand the clamp helpers can describe.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic signed [MAX_W-1:0] sum;
        logic                    ovf;
    } sat_res_t;

    // 2^(w-1)-1, sign-extended to MAX_W bits.
    function automatic logic signed [MAX_W-1:0] sat_max(input int w);
        logic [MAX_W-1:0] m;
        m = {1'b0, {(MAX_W-1){1'b1}}};
        return m >> (MAX_W - w);
    endfunction

    // -2^(w-1), sign-extended to MAX_W bits.
    function automatic logic signed [MAX_W-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/sat_add_core.sv
// Combinational signed a+b with overflow detect and optional clamp.
// Ports: a, b operands; sum result (clamped or wrapped); ovf overflow flag.
module sat_add_core
    import sat_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

    logic [WIDTH:0] exact;

    // Sign-extend by one bit so the exact sum always fits.
    assign exact = {a[WIDTH-1], a} + {b[WIDTH-1], b};

    always_comb begin
        // Top two bits disagree exactly when the result left the range.
        ovf = exact[WIDTH] ^ exact[WIDTH-1];
        sum = exact[WIDTH-1:0];
        if (SATURATE && ovf) begin
            // exact[WIDTH] is the true sign of the unbounded sum.
            sum = exact[WIDTH] ? SMIN : SMAX;
        end
    end

endmodule

// File: rtl/sat_add_acc.sv
// Two-stage valid/ready signed saturating adder/accumulator.
// Ports: in_* operand beat + handshake; out_* result + handshake;
// ovf_sticky/sticky_clr overflow history; clk, rst (async, high).
module sat_add_acc
    import sat_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             ovf_sticky,
    input  logic             sticky_clr
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_mode;
    logic             s1_clr;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] core_sum;
    logic             core_ovf;
    logic             advance;
    logic             load2;

    // One global stall: the whole pipe moves unless a result is
    // waiting on a downstream that is not ready.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign load2    = advance && s1_valid;

    always_comb begin
        op_b = s1_b;
        if (s1_mode == MODE_ACC) begin
            op_b = s1_clr ? '0 : acc;
        end
    end

    sat_add_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .a   (s1_a),
        .b   (op_b),
        .sum (core_sum),
        .ovf (core_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_ADD;
            s1_clr   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_mode <= in_mode;
                s1_clr  <= in_clr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= core_sum;
                out_ovf <= core_ovf;
            end
        end
    end

    // acc follows the final (clamped/wrapped) ACC result, so the next
    // ACC beat sitting in stage 1 sees it without any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load2 && s1_mode == MODE_ACC) begin
            acc <= core_sum;
        end
    end

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (load2 && core_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (sticky_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sat_add_acc.sv
// Directed bench for sat_add_acc: a saturating and a wrapping
// instance share stimulus; expected values are hand-computed.
module tb_sat_add_acc;
    import sat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic in_mode = MODE_ADD;
    logic in_clr = 1'b0;
    logic out_ready = 1'b1;
    logic sticky_clr = 1'b0;

    logic rdy_s, val_s, ovf_s, stk_s;
    logic rdy_w, val_w, ovf_w, stk_w;
    logic signed [7:0] sum_s, sum_w;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sat_add_acc #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_clr(in_clr),
        .out_valid(val_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_ovf(ovf_s),
        .ovf_sticky(stk_s), .sticky_clr(sticky_clr)
    );

    sat_add_acc #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_w),
        .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_clr(in_clr),
        .out_valid(val_w), .out_ready(out_ready),
        .out_sum(sum_w), .out_ovf(ovf_w),
        .ovf_sticky(stk_w), .sticky_clr(sticky_clr)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one cycle (accepted: out_ready is high).
    task automatic send(input logic signed [7:0] a,
                        input logic signed [7:0] b,
                        input logic mode, input logic clr);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_mode = mode;
        in_clr = clr;
        tick();
        in_valid = 1'b0;
    endtask

    sat_res_t exp_q[$];
    logic signed [7:0] held;
    int idx, got, cyc;

    initial begin
        // ---- reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", val_s, 0);
        chk("rst_sum", sum_s, 0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_sticky", stk_s, 0);
        chk("rst_ready", rdy_s, 1);

        // ---- ADD, 2-cycle latency, both modes
        send(100, 27, MODE_ADD, 1'b0);
        chk("lat1_valid", val_s, 0);
        tick();
        chk("add1_valid", val_s, 1);
        chk("add1_sum", sum_s, 127);
        chk("add1_ovf", ovf_s, 0);
        chk("add1_sticky", stk_s, 0);

        send(100, 28, MODE_ADD, 1'b0);
        tick();
        chk("add2_sum", sum_s, 127);
        chk("add2_ovf", ovf_s, 1);
        chk("add2_sticky", stk_s, 1);
        chk("wrap2_sum", sum_w, -128);
        chk("wrap2_ovf", ovf_w, 1);

        send(-100, -29, MODE_ADD, 1'b0);
        tick();
        chk("add3_sum", sum_s, -128);
        chk("add3_ovf", ovf_s, 1);
        chk("wrap3_sum", sum_w, 127);
        chk("wrap3_ovf", ovf_w, 1);

        send(-1, 1, MODE_ADD, 1'b0);
        tick();
        chk("wrap4_sum", sum_w, 0);
        chk("wrap4_ovf", ovf_w, 0);
        tick();
        chk("bubble_valid", val_s, 0);

        // ---- sticky: set wins over clear, clear alone works
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("stk_clr0", stk_s, 0);
        send(100, 28, MODE_ADD, 1'b0);
        sticky_clr = 1'b1;
        tick();
        chk("stk_both_ovf", ovf_s, 1);
        chk("stk_both", stk_s, 1);
        tick();
        sticky_clr = 1'b0;
        chk("stk_clr1", stk_s, 0);

        // ---- ACC back-to-back stream
        in_valid = 1'b1;
        in_mode = MODE_ACC;
        in_b = 8'sd99;
        in_a = 50; in_clr = 1'b1;
        tick();
        in_a = 50; in_clr = 1'b0;
        tick();
        chk("acc1_sum", sum_s, 50);
        in_a = 50; in_clr = 1'b0;
        tick();
        chk("acc2_sum", sum_s, 100);
        chk("acc2_ovf", ovf_s, 0);
        in_a = -20; in_clr = 1'b1;
        tick();
        chk("acc3_sum", sum_s, 127);
        chk("acc3_ovf", ovf_s, 1);
        in_valid = 1'b0;
        tick();
        chk("acc4_sum", sum_s, -20);
        chk("acc4_reg", $signed(dut_s.acc), -20);
        send(10, 0, MODE_ACC, 1'b0);
        tick();
        chk("acc5_sum", sum_s, -10);
        tick();

        // ---- backpressure: 5 ADD beats, 3-cycle stall
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back('{sum: 32'(11 * i), ovf: 1'b0});
        end
        in_mode = MODE_ADD;
        idx = 0;
        got = 0;
        cyc = 0;
        held = '0;
        while (got < 5 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid = (idx < 5);
            in_a = 8'(idx + 1);
            in_b = 8'(10 * (idx + 1));
            #1;
            if (!out_ready) begin
                chk("bp_in_ready", rdy_s, 0);
                if (cyc == 3) held = sum_s;
                else chk("bp_hold", sum_s, held);
            end
            if (val_s && out_ready) begin
                chk("bp_sum", sum_s, exp_q[got].sum);
                chk("bp_ovf", ovf_s, exp_q[got].ovf);
                got++;
            end
            if (in_valid && rdy_s) idx++;
            cyc++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", got, 5);
        chk("bp_sent", idx, 5);
        #1;
        chk("bp_nodup", val_s, 0);

        // ---- reset mid-stream with acc=90
        in_mode = MODE_ACC;
        send(50, 0, MODE_ACC, 1'b1);
        send(40, 0, MODE_ACC, 1'b0);
        tick();
        chk("pre_rst_acc", $signed(dut_s.acc), 90);
        in_valid = 1'b1;
        in_a = 5; in_clr = 1'b0;
        tick();
        in_a = 6;
        tick();
        in_valid = 1'b0;
        chk("inflight", val_s, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", val_s, 0);
        chk("mid_rst_sum", sum_s, 0);
        chk("mid_rst_ovf", ovf_s, 0);
        chk("mid_rst_acc", $signed(dut_s.acc), 0);
        chk("mid_rst_ready", rdy_s, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", val_s, 0);
        send(10, 0, MODE_ACC, 1'b0);
        tick();
        chk("post_rst_acc", sum_s, 10);
        chk("post_rst_ovf", ovf_s, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sat_add_acc.md
# sat_add_acc

Parametrised, pipelined signed saturating adder/accumulator for the MAC datapath. It generalises the fixed 8-bit saturating adder to WIDTH bits, adds a selectable wrap/saturate mode and a running-accumulate mode, and reports per-result and sticky overflow. It has a two-stage valid/ready pipeline with full backpressure, and sits between the multiplier array output and the MAC result buffer.

## Interface
- WIDTH, 8, operand/result width in bits, two's complement, ≥2
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH (overflow still flagged)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- in_a  in  WIDTH  signed operand A
- in_b  in  WIDTH  signed operand B (ignored in accumulate mode)
- in_mode  in  1  0 = ADD (A+B), 1 = ACC (acc+A)
- in_clr  in  1  with ACC beat: treat acc as 0 before adding
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  signed result
- out_ovf  out  1  this result overflowed (clamped or wrapped)
- ovf_sticky  out  1  set by any overflow since last clear
- sticky_clr  in  1  clear ovf_sticky

## Operation
- Beat accepted when in_valid && in_ready; captured into stage 1 (operands, mode, clr).
- Stage 2 computes the (WIDTH+1)-bit exact sum and registers out_sum/out_ovf/out_valid.
  - ADD: exact = a + b. ACC: exact = (clr ? 0 : acc) + a.
- Overflow: exact > 2^(W-1)-1 or exact < -2^(W-1), equivalently the operand signs are equal and the result sign differs.
- SATURATE=1: clamp to 2^(W-1)-1 / -2^(W-1). SATURATE=0: low WIDTH bits.
- acc register updates only when an ACC beat moves into stage 2, to the final (clamped/wrapped) out_sum. ADD beats leave acc untouched.
- ovf_sticky: set when a stage-2 load has out_ovf=1. Cleared by sticky_clr. Simultaneous set and clear: set wins.
- Reset: out_valid=0, stage-1 valid=0, out_sum=0, out_ovf=0, acc=0, ovf_sticky=0. in_ready=1 after reset. Reset mid-operation drops all in-flight beats and the accumulator.

## Timing
- Latency: 2 cycles from acceptance to out_valid with no stall.
- Throughput: 1 beat/cycle.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
  - When advance=0, both stages hold and out_sum/out_ovf stay stable while out_valid=1.
  - A stage-1 bubble may advance into stage 2 (out_valid drops next cycle).
- Back-to-back ACC beats: each beat sees the acc produced by the immediately preceding ACC beat. The feedback is contained in stage 2, so no hazard stall.
- out_ovf is valid only with out_valid. ovf_sticky is independent of the handshake.

## Structure
- Package sat_pkg holds:
  - the mode constants MODE_ADD=0 and MODE_ACC=1;
  - the function sat_max/sat_min(WIDTH);
  - a result struct {sum, ovf}.
- One sub-module, sat_add_core: combinational WIDTH-parametrised a+b, producing sum and ovf under the SATURATE parameter. It is instantiated once in stage 2 with operand B muxed between in_b and acc/0.
- Top level holds the stage registers, handshake, acc and sticky logic.

## Test plan
- WIDTH=8, SATURATE=1, ADD: 100+27 → 127, ovf=0. 100+28 → 127, ovf=1. -100+-29 → -128, ovf=1. Each appears 2 cycles after acceptance, and ovf_sticky=1 after the first overflow.
- WIDTH=8, SATURATE=0, ADD: 100+28 → -128, ovf=1. -1+1 → 0, ovf=0.
- ACC: beats a=50 (clr=1), 50, 50, then a=-20 (clr=1), streamed back-to-back → 50, 100, 127 (ovf=1), -20. The acc register equals the last output.
- Backpressure: stream 5 ADD beats and hold out_ready=0 for 3 cycles mid-stream → in_ready low, out_sum held stable, all 5 results delivered in order with no loss or duplication.
- Sticky: overflow result loads in the same cycle as sticky_clr=1 → ovf_sticky=1. A sticky_clr pulse alone afterwards → 0.
- Reset mid-stream, with 2 beats in flight and acc=90 → outputs are at reset values immediately. The next ACC beat a=10 (clr=0) → 10.
